// File: rtl/serial_full_subtractor.sv
// Bit-serial LSB-first subtractor (a - b): one full-subtractor slice and a registered borrow, WIDTH RUN cycles per op.
// Latency: start accepted at T0, result and done pulse after edge T_WIDTH; one operation every WIDTH+2 cycles.
// Backpressure: none; start_in is sampled only in IDLE and ignored otherwise. Macro SERIAL_SUB_OVF_EN adds signed overflow.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic             busy_next;
  logic             done_next;
  logic             accept;
  logic             last_bit;
  logic             bit_d;
  logic             br_next;

  assign accept   = (state == IDLE) && start_in;
  assign last_bit = (state == RUN) && (cnt == LAST);

  // Single full-subtractor slice on the current LSBs.
  assign bit_d   = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_in) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Flags are computed from the next state so the registered outputs line up with the state.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= a_in;
      b_sr <= b_in;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {bit_d, d_sr[WIDTH-1:1]};
      br   <= br_next;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers only move on completion, so they hold through a following RUN.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (last_bit) begin
      diff_q   <= {bit_d, d_sr[WIDTH-1:1]};
      borrow_q <= br_next;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // bit_d on the last RUN edge is the difference MSB.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a_in[WIDTH-1];
        b_msb <= b_in[WIDTH-1];
      end
      if (last_bit) begin
        ovf_q <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
      end
    end
  end

  assign ovf_out = ovf_q;
`else
  assign ovf_out = 1'b0;
`endif

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign diff_out   = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Randomized self-checking bench for serial_full_subtractor (WIDTH=8) against an arithmetic reference.
module tb_serial_full_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int chk_total = 0;
  int chk_pass  = 0;

  logic [W-1:0] last_diff   = '0;
  logic         last_borrow = 1'b0;
  logic         last_ovf    = 1'b0;

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .start_in   (start),
    .a_in       (a),
    .b_in       (b),
    .busy_out   (busy),
    .done_out   (done),
    .diff_out   (diff),
    .borrow_out (borrow),
    .ovf_out    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got === exp) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int ua;
    int ub;
    int sd;
    ua = int'(ma);
    ub = int'(mb);
    ed = W'((ua - ub + 256) % 256);
    eb = (ua < ub);
    sd = int'($signed(ma)) - int'($signed(mb));
`ifdef SERIAL_SUB_OVF_EN
    eo = (sd < -128) || (sd > 127);
`else
    eo = 1'b0;
`endif
  endtask

  // One operation; inj >= 0 pulses a bogus start at that RUN cycle.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int inj);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           busy_cnt;
    int           done_cnt;
    model(oa, ob, ed, eb, eo);
    @(negedge clk);
    start = 1'b1;
    a = oa;
    b = ob;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    busy_cnt = 0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("diff", 32'(diff), 32'(ed));
        check("borrow", 32'(borrow), 32'(eb));
        check("ovf", 32'(ovf), 32'(eo));
        last_diff   = ed;
        last_borrow = eb;
        last_ovf    = eo;
      end else if (n == 3) begin
        check("hold_diff", 32'(diff), 32'(last_diff));
        check("hold_borrow", 32'(borrow), 32'(last_borrow));
      end
      if (!busy) break;
      if (n == inj) begin
        start = 1'b1;
        a = 8'd99;
        b = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 32'(busy_cnt), 32'(W + 1));
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int pulses;
    int last_at;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    run_op(8'd200, 8'd45, -1);
    run_op(8'd45, 8'd200, -1);
    run_op(8'h80, 8'h01, -1);
    run_op(8'd10, 8'd3, 2);
    run_op(8'h7F, 8'hFF, -1);
    run_op(8'h00, 8'hFF, -1);

    // Start held high: a new op every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1;
    a = '0;
    b = '0;
    pulses = 0;
    last_at = -1;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("b2b_diff", 32'(diff), 32'd0);
        check("b2b_borrow", 32'(borrow), 32'd0);
        check("b2b_ovf", 32'(ovf), 32'd0);
        if (last_at >= 0) check("b2b_period", 32'(n - last_at), 32'(W + 2));
        last_at = n;
        last_diff = '0;
        last_borrow = 1'b0;
        last_ovf = 1'b0;
      end else begin
        check("b2b_stable", 32'(diff), 32'(last_diff));
      end
    end
    check("b2b_pulses_ge3", 32'(pulses >= 3), 32'd1);
    start = 1'b0;
    for (int n = 0; n < 20 && busy; n++) @(negedge clk);
    check("b2b_drain", 32'(busy), 32'd0);

    // Reset during RUN aborts and clears outputs.
    run_op(8'd200, 8'd45, -1);
    @(negedge clk);
    start = 1'b1;
    a = 8'd10;
    b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("arst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    last_diff = '0;
    last_borrow = 1'b0;
    last_ovf = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) check("arst_spurious_done", 32'(done), 32'd0);
    end
    run_op(8'd5, 8'd9, -1);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule

// File: doc/serial_full_subtractor.md
# serial_full_subtractor

Bit-serial, LSB-first two's-complement subtractor that computes `a_in - b_in` over WIDTH cycles. It uses one full-subtractor slice and a registered borrow, so it is the inverse-operation companion to the team's combinational adder primitives. It sits beside the adder datapath wherever area matters more than latency. Operands are loaded with a start handshake, and the result is presented with a one-cycle done pulse.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- `clk_in`: input, 1 bit. Rising-edge clock.
- `rst_n_in`: input, 1 bit. Asynchronous, active-low reset.
- `start_in`: input, 1 bit. Request to begin a subtraction; sampled only in IDLE.
- `a_in`: input, WIDTH bits. Minuend; captured on the accepted start.
- `b_in`: input, WIDTH bits. Subtrahend; captured on the accepted start.
- `busy_out`: output, 1 bit. High while state ≠ IDLE.
- `done_out`: output, 1 bit. One-cycle pulse when the result is updated.
- `diff_out`: output, WIDTH bits. Result register, `(a - b) mod 2^WIDTH`.
- `borrow_out`: output, 1 bit. Final borrow; 1 iff a < b, unsigned.
- `ovf_out`: output, 1 bit. Signed overflow flag; see Configuration.

One clock, `clk_in`. Reset `rst_n_in` is asynchronous and active-low.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:** on `start_in`=1 at a clock edge:
  - load the A and B shift registers from `a_in` and `b_in`;
  - clear the borrow register and the bit counter;
  - go to RUN.
- **RUN:** each edge processes bit 0 of the shift registers:
  - `d = a0 ^ b0 ^ br`
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - A and B shift right; `d` shifts into the MSB of the internal difference shift register; the counter increments.
- **End of RUN:** on the edge where the counter reaches WIDTH-1, i.e. the WIDTH-th RUN edge:
  - `diff_out` ← the completed difference;
  - `borrow_out` ← `br_next`;
  - `ovf_out` ← overflow per Configuration;
  - go to DONE.
- **DONE:** `done_out`=1 for exactly this one cycle; next edge goes to IDLE unconditionally.
- **Start outside IDLE:** `start_in` in RUN or DONE is ignored, not queued.
- **Result hold:** `diff_out`, `borrow_out` and `ovf_out` hold their values until the next completion. They do not change during a subsequent RUN.
- **Input changes:** `a_in` and `b_in` may change freely after the accepting edge.

## Timing
- **Reset:**
  - state = IDLE;
  - `busy_out`, `done_out`, `borrow_out`, `ovf_out` = 0;
  - `diff_out` = 0;
  - internal shift registers, counter and borrow = 0.
- **Reset mid-operation:** the computation is aborted immediately. The previous result is lost (outputs cleared), and no `done_out` is produced.
- **Latency:** start accepted at edge T0. RUN occupies edges T1..T_WIDTH. `done_out` is high between edges T_WIDTH and T_WIDTH+1.
- **Throughput:** the earliest next start is accepted at edge T_WIDTH+2, so one operation every WIDTH+2 cycles.
- **Output registers:** all outputs are registered; no combinational path from inputs to outputs.
- **Busy:** `busy_out` rises after T0 and falls after T_WIDTH+1.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- **Defined:** at completion, `ovf_out` = `(a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, using the captured MSBs. An extra MSB-capture register is built.
- **Undefined:** `ovf_out` is constant 0. The port remains present and no overflow logic is synthesized.

## Test plan
All cases WIDTH=8.
1. a=200, b=45, pulse start → after 8 RUN cycles `done_out` pulses with `diff_out`=155 and `borrow_out`=0; `busy_out` high for exactly 9 cycles.
2. a=45, b=200 → `diff_out`=0x65 (101), `borrow_out`=1; `ovf_out`=0 with the macro, since signed 45-(-56)=101.
3. a=0x80, b=0x01 → `diff_out`=0x7F, `borrow_out`=0; `ovf_out`=1 with `SERIAL_SUB_OVF_EN`, 0 without it.
4. a=0, b=0, then back-to-back start held high continuously → results 0/0/0. A new operation is accepted every 10 cycles, and `diff_out` is stable between pulses.
5. Start in RUN: start a=10,b=3, pulse start again with a=99,b=1 during RUN → ignored; result 7.
6. Assert `rst_n_in` low at RUN cycle 4 → all outputs 0 immediately, no `done_out`. After release, the next start a=5,b=9 gives `diff_out`=0xFC and `borrow_out`=1.
